// File: rtl/mem_axi_pkg.sv
// Shared types and constants for the single-beat write responder.
package mem_axi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [3:0] SIZE_1B = 4'b0001;
  localparam logic [3:0] SIZE_2B = 4'b0010;
  localparam logic [3:0] SIZE_4B = 4'b0100;
  localparam logic [3:0] SIZE_8B = 4'b1000;

  // Byte mask for a size code; unknown codes behave as a full 8-byte store.
  function automatic logic [7:0] size_mask(input logic [3:0] code);
    logic [7:0] m;
    case (code)
      SIZE_1B: m = 8'h01;
      SIZE_2B: m = 8'h03;
      SIZE_4B: m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/wstrb_gen.sv
// Lane placement of a store: byte strobe, shifted data and alignment flag.
module wstrb_gen
  import mem_axi_pkg::*;
(
  input  logic [3:0]  size_code,
  input  logic [2:0]  addr_lo,
  input  logic [63:0] wdata,
  output logic [7:0]  wstrb,
  output logic [63:0] wdata_lane,
  output logic        misaligned
);

  // Shift mask and data into the addressed lanes and flag unnatural alignment.
  always_comb begin
    wstrb      = size_mask(size_code) << addr_lo;
    wdata_lane = wdata << {addr_lo, 3'b000};
    case (size_code)
      SIZE_1B: misaligned = 1'b0;
      SIZE_2B: misaligned = (addr_lo[0] != 1'b0);
      SIZE_4B: misaligned = (addr_lo[1:0] != 2'b00);
      default: misaligned = (addr_lo != 3'b000);
    endcase
  end

endmodule

// File: rtl/mem_write_resp.sv
// Single-beat write responder: collects AW and W in any order, validates the
// request, performs one backing-memory write and returns the B response.
module mem_write_resp
  import mem_axi_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter logic [31:0] MEM_SIZE  = 32'h0800_0000
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        AWVALID,
  output logic        AWREADY,
  input  logic [31:0] AWADDR,
  input  logic        WVALID,
  output logic        WREADY,
  input  logic [63:0] WDATA,
  input  logic        WLAST,
  input  logic [3:0]  WUSER,
  output logic        BVALID,
  input  logic        BREADY,
  output logic [1:0]  BRESP,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wstrb,
  input  logic        mem_ready
);

  state_e      state_q, state_d;
  logic        aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [3:0]  wuser_q, wuser_d;
  logic        wlast_q, wlast_d;
  logic        awready_q, awready_d, wready_q, wready_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        mem_wen_q, mem_wen_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [63:0] mem_wdata_q, mem_wdata_d;
  logic [7:0]  mem_wstrb_q, mem_wstrb_d;

  logic        aw_hs_s, w_hs_s;
  logic [31:0] cur_addr_s;
  logic [63:0] cur_data_s;
  logic [3:0]  cur_user_s;
  logic        cur_last_s;
  logic        in_range_s, misaligned_s, err_s;
  logic [7:0]  strb_s;
  logic [63:0] lane_data_s;

  // READY is only ever high in IDLE, so a handshake implies IDLE.
  assign aw_hs_s    = AWVALID & awready_q;
  assign w_hs_s     = WVALID & wready_q;
  assign cur_addr_s = aw_hs_s ? AWADDR : awaddr_q;
  assign cur_data_s = w_hs_s ? WDATA : wdata_q;
  assign cur_user_s = w_hs_s ? WUSER : wuser_q;
  assign cur_last_s = w_hs_s ? WLAST : wlast_q;

  // Window check without wrap: offset from base must fall below the size.
  assign in_range_s = (cur_addr_s >= BASE_ADDR) && ((cur_addr_s - BASE_ADDR) < MEM_SIZE);
  assign err_s      = !in_range_s || misaligned_s || !cur_last_s;

  wstrb_gen u_wstrb_gen (
    .size_code  (cur_user_s),
    .addr_lo    (cur_addr_s[2:0]),
    .wdata      (cur_data_s),
    .wstrb      (strb_s),
    .wdata_lane (lane_data_s),
    .misaligned (misaligned_s)
  );

  // Next-state and next-output decode for the IDLE/WRITE/RESP sequence.
  always_comb begin
    state_d     = state_q;
    aw_held_d   = aw_held_q;
    w_held_d    = w_held_q;
    awaddr_d    = awaddr_q;
    wdata_d     = wdata_q;
    wuser_d     = wuser_q;
    wlast_d     = wlast_q;
    awready_d   = awready_q;
    wready_d    = wready_q;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    mem_wen_d   = mem_wen_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    case (state_q)
      ST_IDLE: begin
        aw_held_d = aw_held_q | aw_hs_s;
        w_held_d  = w_held_q | w_hs_s;
        awaddr_d  = cur_addr_s;
        wdata_d   = cur_data_s;
        wuser_d   = cur_user_s;
        wlast_d   = cur_last_s;
        if (aw_held_d && w_held_d) begin
          awready_d = 1'b0;
          wready_d  = 1'b0;
          if (err_s) begin
            state_d  = ST_RESP;
            bvalid_d = 1'b1;
            bresp_d  = RESP_SLVERR;
          end else begin
            state_d     = ST_WRITE;
            mem_wen_d   = 1'b1;
            mem_addr_d  = {cur_addr_s[31:3], 3'b000};
            mem_wdata_d = lane_data_s;
            mem_wstrb_d = strb_s;
          end
        end else begin
          awready_d = !aw_held_d;
          wready_d  = !w_held_d;
        end
      end
      ST_WRITE: begin
        if (mem_ready) begin
          state_d   = ST_RESP;
          mem_wen_d = 1'b0;
          bvalid_d  = 1'b1;
          bresp_d   = RESP_OKAY;
        end else begin
          mem_wen_d = 1'b1;
        end
      end
      ST_RESP: begin
        if (BREADY) begin
          state_d   = ST_IDLE;
          bvalid_d  = 1'b0;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end else begin
          bvalid_d = 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        aw_held_d = 1'b0;
        w_held_d  = 1'b0;
        awready_d = 1'b0;
        wready_d  = 1'b0;
        bvalid_d  = 1'b0;
        mem_wen_d = 1'b0;
      end
    endcase
  end

  // State, holding registers and registered outputs; reset abandons any transfer.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q     <= ST_IDLE;
      aw_held_q   <= 1'b0;
      w_held_q    <= 1'b0;
      awaddr_q    <= 32'h0;
      wdata_q     <= 64'h0;
      wuser_q     <= 4'h0;
      wlast_q     <= 1'b0;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= RESP_OKAY;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 64'h0;
      mem_wstrb_q <= 8'h0;
    end else begin
      state_q     <= state_d;
      aw_held_q   <= aw_held_d;
      w_held_q    <= w_held_d;
      awaddr_q    <= awaddr_d;
      wdata_q     <= wdata_d;
      wuser_q     <= wuser_d;
      wlast_q     <= wlast_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      mem_wen_q   <= mem_wen_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
    end
  end

  assign AWREADY   = awready_q;
  assign WREADY    = wready_q;
  assign BVALID    = bvalid_q;
  assign BRESP     = bresp_q;
  assign mem_wen   = mem_wen_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;

endmodule

// File: tb/tb_mem_write_resp.sv
// Self-checking bench for mem_write_resp with a scoreboard of expected writes.
module tb_mem_write_resp;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        AWVALID = 1'b0, WVALID = 1'b0, BREADY = 1'b0, mem_ready = 1'b0;
  logic        WLAST = 1'b1;
  logic [31:0] AWADDR = 32'h0;
  logic [63:0] WDATA = 64'h0;
  logic [3:0]  WUSER = 4'h0;
  logic        AWREADY, WREADY, BVALID, mem_wen;
  logic [1:0]  BRESP;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;

  mem_write_resp dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WLAST(WLAST), .WUSER(WUSER),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
    logic [1:0]  resp;
    bit          wr;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  int obs_hs, obs_wen_first, obs_b_first, obs_wen_cnt, obs_b_cnt;
  bit obs_pay_stable, obs_resp_stable, obs_leak, obs_timeout;
  logic obs_awready_after, obs_wready_after;
  logic [31:0] obs_addr;
  logic [63:0] obs_data;
  logic [7:0]  obs_strb;
  logic [1:0]  obs_resp;

  // Reference model: byte-by-byte placement and a 64-bit window check.
  function automatic exp_t model(input logic [31:0] a, input logic [3:0] u,
                                 input logic [63:0] d, input logic l);
    exp_t e;
    int n;
    int off;
    bit bad;
    case (u)
      4'b0001: n = 1;
      4'b0010: n = 2;
      4'b0100: n = 4;
      default: n = 8;
    endcase
    off = int'(a[2:0]);
    bad = ({32'h0, a} < 64'h8000_0000) || ({32'h0, a} >= 64'h8800_0000) ||
          ((off % n) != 0) || (l !== 1'b1);
    e.addr = {a[31:3], 3'b000};
    e.strb = 8'h00;
    e.data = 64'h0;
    for (int i = 0; i < 8; i++) begin
      if (i >= off && i < off + n) e.strb[i] = 1'b1;
      if (i >= off) e.data[8*i +: 8] = d[8*(i-off) +: 8];
    end
    e.resp = bad ? 2'b10 : 2'b00;
    e.wr   = !bad;
    return e;
  endfunction

  // Drives one transaction cycle by cycle (entered and left at a falling edge)
  // and records what the DUT did; it makes no judgement itself.
  task automatic do_txn(input logic [31:0] a, input logic [3:0] u, input logic [63:0] d,
                        input logic l, input int aw_dly, input int w_dly,
                        input int r_stall, input int b_stall);
    bit aw_done = 0, w_done = 0, b_done = 0;
    int c = 0;
    obs_hs = -1; obs_wen_first = -1; obs_b_first = -1; obs_wen_cnt = 0; obs_b_cnt = 0;
    obs_pay_stable = 1; obs_resp_stable = 1; obs_leak = 0; obs_timeout = 0;
    obs_awready_after = 1'b0; obs_wready_after = 1'b0;
    obs_resp = 2'b11;
    AWADDR = a; WUSER = u; WDATA = d; WLAST = l;
    while (1) begin
      if (b_done) begin
        obs_awready_after = AWREADY;
        obs_wready_after  = WREADY;
        break;
      end
      if (obs_hs >= 0 && c > obs_hs && (AWREADY || WREADY)) obs_leak = 1;
      if (mem_wen) begin
        obs_wen_cnt++;
        if (obs_wen_cnt == 1) begin
          obs_wen_first = c; obs_addr = mem_addr; obs_data = mem_wdata; obs_strb = mem_wstrb;
        end else if (mem_addr !== obs_addr || mem_wdata !== obs_data || mem_wstrb !== obs_strb) begin
          obs_pay_stable = 0;
        end
      end
      mem_ready = mem_wen && (obs_wen_cnt > r_stall);
      if (BVALID) begin
        obs_b_cnt++;
        if (obs_b_cnt == 1) begin
          obs_b_first = c; obs_resp = BRESP;
        end else if (BRESP !== obs_resp) begin
          obs_resp_stable = 0;
        end
      end
      BREADY = BVALID && (obs_b_cnt > b_stall);
      if (BVALID && BREADY) b_done = 1;
      AWVALID = !aw_done && (c >= aw_dly);
      WVALID  = !w_done && (c >= w_dly);
      if (AWVALID && AWREADY) aw_done = 1;
      if (WVALID && WREADY) w_done = 1;
      if (aw_done && w_done && obs_hs < 0) obs_hs = c;
      if (c > 300) begin
        obs_timeout = 1;
        break;
      end
      @(posedge ACLK);
      @(negedge ACLK);
      c++;
    end
    AWVALID = 1'b0; WVALID = 1'b0; mem_ready = 1'b0; BREADY = 1'b0;
  endtask

  task automatic test_reset();
    ARESET = 1'b1;
    repeat (2) @(negedge ACLK);
    checks++; if (AWREADY !== 1'b0) begin failures++; $display("FAIL reset_awready got=%b exp=0", AWREADY); end
    checks++; if (WREADY !== 1'b0) begin failures++; $display("FAIL reset_wready got=%b exp=0", WREADY); end
    checks++; if (BVALID !== 1'b0 || mem_wen !== 1'b0) begin failures++; $display("FAIL reset_valids bvalid=%b mem_wen=%b exp=0", BVALID, mem_wen); end
    checks++; if (BRESP !== 2'b00) begin failures++; $display("FAIL reset_bresp got=%b exp=00", BRESP); end
    checks++; if (mem_addr !== 32'h0 || mem_wdata !== 64'h0 || mem_wstrb !== 8'h0) begin
      failures++; $display("FAIL reset_payload addr=%h data=%h strb=%h exp=0", mem_addr, mem_wdata, mem_wstrb); end
    ARESET = 1'b0;
    @(negedge ACLK);
    checks++; if (AWREADY !== 1'b1 || WREADY !== 1'b1) begin
      failures++; $display("FAIL reset_ready_rise awready=%b wready=%b exp=1", AWREADY, WREADY); end
  endtask

  task automatic test_same_cycle();
    exp_t e;
    exp_q.push_back(model(32'h8000_0004, 4'b0100, 64'h1122_3344, 1'b1));
    do_txn(32'h8000_0004, 4'b0100, 64'h1122_3344, 1'b1, 0, 0, 0, 0);
    e = exp_q.pop_front();
    checks++; if (obs_timeout) begin failures++; $display("FAIL same_timeout got=timeout exp=response"); end
    checks++; if (obs_strb !== 8'hF0 || obs_strb !== e.strb) begin failures++; $display("FAIL same_wstrb got=%h exp=%h", obs_strb, e.strb); end
    checks++; if (obs_data !== 64'h1122_3344_0000_0000 || obs_data !== e.data) begin failures++; $display("FAIL same_wdata got=%h exp=%h", obs_data, e.data); end
    checks++; if (obs_addr !== e.addr) begin failures++; $display("FAIL same_addr got=%h exp=%h", obs_addr, e.addr); end
    checks++; if (obs_resp !== e.resp) begin failures++; $display("FAIL same_bresp got=%b exp=%b", obs_resp, e.resp); end
    checks++; if (obs_wen_first - obs_hs !== 1) begin failures++; $display("FAIL same_wen_latency got=%0d exp=1", obs_wen_first - obs_hs); end
    checks++; if (obs_b_first - obs_hs !== 2) begin failures++; $display("FAIL same_b_latency got=%0d exp=2", obs_b_first - obs_hs); end
    checks++; if (obs_awready_after !== 1'b1) begin failures++; $display("FAIL same_awready_after got=%b exp=1", obs_awready_after); end
  endtask

  task automatic test_w_before_aw();
    exp_t e;
    exp_q.push_back(model(32'h8000_0001, 4'b0001, 64'hAB, 1'b1));
    do_txn(32'h8000_0001, 4'b0001, 64'hAB, 1'b1, 3, 0, 0, 0);
    e = exp_q.pop_front();
    checks++; if (obs_wen_cnt !== 1) begin failures++; $display("FAIL wfirst_wen_pulses got=%0d exp=1", obs_wen_cnt); end
    checks++; if (obs_strb !== e.strb) begin failures++; $display("FAIL wfirst_wstrb got=%h exp=%h", obs_strb, e.strb); end
    checks++; if (obs_data[15:8] !== 8'hAB || obs_data !== e.data) begin failures++; $display("FAIL wfirst_wdata got=%h exp=%h", obs_data, e.data); end
    checks++; if (obs_resp !== e.resp) begin failures++; $display("FAIL wfirst_bresp got=%b exp=%b", obs_resp, e.resp); end
    checks++; if (obs_hs !== 3) begin failures++; $display("FAIL wfirst_hs_cycle got=%0d exp=3", obs_hs); end
  endtask

  logic [31:0] err_addr [8] = '{32'h7FFF_FFF8, 32'h8800_0000, 32'h8000_0002, 32'h8000_0000,
                                32'h87FF_FFF8, 32'hFFFF_FFF8, 32'h8000_0003, 32'h8000_0006};
  logic [3:0]  err_user [8] = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0010, 4'b0010};
  logic        err_last [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  task automatic test_errors();
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(model(err_addr[i], err_user[i], 64'h0102_0304_0506_0708, err_last[i]));
      do_txn(err_addr[i], err_user[i], 64'h0102_0304_0506_0708, err_last[i], i % 3, 0, 0, 0);
      e = exp_q.pop_front();
      checks++; if (obs_resp !== e.resp) begin failures++; $display("FAIL err%0d_bresp got=%b exp=%b", i, obs_resp, e.resp); end
      checks++; if (obs_wen_cnt !== (e.wr ? 1 : 0)) begin failures++; $display("FAIL err%0d_wen got=%0d exp=%0d", i, obs_wen_cnt, e.wr ? 1 : 0); end
      checks++; if (obs_b_first - obs_hs !== (e.wr ? 2 : 1)) begin failures++; $display("FAIL err%0d_b_latency got=%0d exp=%0d", i, obs_b_first - obs_hs, e.wr ? 2 : 1); end
      if (e.wr) begin
        checks++; if (obs_strb !== e.strb || obs_data !== e.data || obs_addr !== e.addr) begin
          failures++; $display("FAIL err%0d_payload got=%h/%h/%h exp=%h/%h/%h", i, obs_addr, obs_data, obs_strb, e.addr, e.data, e.strb); end
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    exp_q.push_back(model(32'h8000_0010, 4'b1000, 64'hDEAD_BEEF_CAFE_F00D, 1'b1));
    do_txn(32'h8000_0010, 4'b1000, 64'hDEAD_BEEF_CAFE_F00D, 1'b1, 0, 1, 5, 3);
    e = exp_q.pop_front();
    checks++; if (obs_wen_cnt !== 6) begin failures++; $display("FAIL bp_wen_cycles got=%0d exp=6", obs_wen_cnt); end
    checks++; if (!obs_pay_stable) begin failures++; $display("FAIL bp_payload_stable got=changed exp=stable"); end
    checks++; if (obs_b_cnt !== 4) begin failures++; $display("FAIL bp_bvalid_cycles got=%0d exp=4", obs_b_cnt); end
    checks++; if (!obs_resp_stable || obs_resp !== e.resp) begin failures++; $display("FAIL bp_bresp got=%b exp=%b", obs_resp, e.resp); end
    checks++; if (obs_leak) begin failures++; $display("FAIL bp_ready_leak got=ready_high exp=low"); end
    checks++; if (obs_data !== e.data || obs_strb !== e.strb) begin failures++; $display("FAIL bp_payload got=%h/%h exp=%h/%h", obs_data, obs_strb, e.data, e.strb); end
  endtask

  task automatic test_reset_mid_write();
    exp_t e;
    AWADDR = 32'h8000_0020; WUSER = 4'b1000; WDATA = 64'h55; WLAST = 1'b1;
    mem_ready = 1'b0; AWVALID = 1'b1; WVALID = 1'b1;
    @(posedge ACLK); @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b0;
    checks++; if (mem_wen !== 1'b1) begin failures++; $display("FAIL rmid_in_write got=%b exp=1", mem_wen); end
    #2 ARESET = 1'b1;
    #1;
    checks++; if (mem_wen !== 1'b0 || BVALID !== 1'b0) begin failures++; $display("FAIL rmid_drop mem_wen=%b bvalid=%b exp=0", mem_wen, BVALID); end
    @(negedge ACLK);
    ARESET = 1'b0;
    BREADY = 1'b1;
    repeat (3) @(negedge ACLK);
    checks++; if (BVALID !== 1'b0 || mem_wen !== 1'b0) begin failures++; $display("FAIL rmid_no_resp bvalid=%b mem_wen=%b exp=0", BVALID, mem_wen); end
    BREADY = 1'b0;
    exp_q.push_back(model(32'h8000_0008, 4'b0010, 64'h9876, 1'b1));
    do_txn(32'h8000_0008, 4'b0010, 64'h9876, 1'b1, 0, 0, 0, 0);
    e = exp_q.pop_front();
    checks++; if (obs_resp !== e.resp || obs_wen_cnt !== 1 || obs_strb !== e.strb || obs_data !== e.data) begin
      failures++; $display("FAIL rmid_after resp=%b wen=%0d strb=%h data=%h exp=%b/1/%h/%h", obs_resp, obs_wen_cnt, obs_strb, obs_data, e.resp, e.strb, e.data); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [31:0] a;
    logic [3:0] u;
    logic [63:0] d;
    logic l;
    int rs, bs;
    logic [3:0] codes [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011};
    for (int i = 0; i < 12; i++) begin
      a  = 32'h8000_0000 + ($urandom_range(0, 63) * 8) + $urandom_range(0, 7);
      if (i % 5 == 4) a = 32'h9000_0000 + $urandom_range(0, 7);
      u  = codes[$urandom_range(0, 4)];
      d  = {$urandom, $urandom};
      l  = ($urandom_range(0, 7) != 0);
      rs = $urandom_range(0, 2);
      bs = $urandom_range(0, 2);
      exp_q.push_back(model(a, u, d, l));
      do_txn(a, u, d, l, $urandom_range(0, 3), $urandom_range(0, 3), rs, bs);
      e = exp_q.pop_front();
      checks++; if (obs_timeout || obs_resp !== e.resp) begin failures++; $display("FAIL b2b%0d_bresp got=%b exp=%b", i, obs_resp, e.resp); end
      checks++; if (obs_wen_cnt !== (e.wr ? rs + 1 : 0) || obs_b_cnt !== bs + 1) begin
        failures++; $display("FAIL b2b%0d_counts wen=%0d b=%0d exp=%0d/%0d", i, obs_wen_cnt, obs_b_cnt, e.wr ? rs + 1 : 0, bs + 1); end
      if (e.wr) begin
        checks++; if (obs_strb !== e.strb || obs_data !== e.data || obs_addr !== e.addr) begin
          failures++; $display("FAIL b2b%0d_payload got=%h/%h/%h exp=%h/%h/%h", i, obs_addr, obs_data, obs_strb, e.addr, e.data, e.strb); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_same_cycle();
    test_w_before_aw();
    test_errors();
    test_backpressure();
    test_reset_mid_write();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
